// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: selector encoding, legality
// helpers and the result record held by both storage entries.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_J     = 3'd3,
        IMM_U     = 3'd4,
        IMM_Z     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_RSVD  = 3'd7
    } imm_src_e;

    localparam int XLEN_MAX = 64;
    localparam int TAG_MAX  = 64;

    // Sized for the widest configuration; narrower builds use the low bits.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        logic [TAG_MAX-1:0]  tag;
        logic                illegal;
    } imm_res_t;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction from an RV32/RV64 instruction word.
// Reserved selectors yield zero with the illegal flag set.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ins,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // The opcode field never contributes to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^ins[6:0];

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_src_e'(imm_src))
            IMM_I:     imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
            IMM_S:     imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:     imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:     imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_U:     imm = XLEN'($signed({ins[31:12], 12'b0}));
            IMM_Z:     imm = XLEN'(ins[19:15]);
            // RV64 shift amounts carry one extra bit.
            IMM_SHAMT: imm = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
            IMM_RSVD:  illegal = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: one-cycle latency, output register plus
// skid entry for full throughput, and a saturating illegal-selector counter.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          ins,
    input  logic [2:0]           imm_src,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      imm_op,
    output logic [TAG_W-1:0]     tag_out,
    output logic                 illegal,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (TAG_W < 1 || TAG_W > TAG_MAX) begin : g_bad_tag
        $error("imm_gen_pipe: TAG_W out of range");
    end

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [XLEN-1:0]      dec_imm;
    logic                 dec_illegal;
    imm_res_t             dec_res;

    imm_res_t             main_reg, main_next;
    logic                 main_valid_reg, main_valid_next;
    imm_res_t             skid_reg, skid_next;
    logic                 skid_valid_reg, skid_valid_next;
    logic                 in_ready_reg;
    logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;

    logic                 accept;
    logic                 retire;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .ins     (ins),
        .imm_src (imm_src),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec_res                 = '0;
        dec_res.imm[XLEN-1:0]   = dec_imm;
        dec_res.tag[TAG_W-1:0]  = tag_in;
        dec_res.illegal         = dec_illegal;
    end

    assign accept = in_valid && in_ready_reg;
    assign retire = main_valid_reg && out_ready;

    always_comb begin
        main_next       = main_reg;
        main_valid_next = main_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;

        if (retire) begin
            main_valid_next = 1'b0;
        end
        if (skid_valid_reg && retire) begin
            main_next       = skid_reg;
            main_valid_next = 1'b1;
            skid_valid_next = 1'b0;
        end
        // New data goes straight to main only when nothing older is queued.
        if (accept) begin
            if ((!main_valid_reg || retire) && !skid_valid_reg) begin
                main_next       = dec_res;
                main_valid_next = 1'b1;
            end else begin
                skid_next       = dec_res;
                skid_valid_next = 1'b1;
            end
        end
    end

    always_comb begin
        err_count_next = err_count_reg;
        if (err_clr) begin
            err_count_next = '0;
        end else if (accept && dec_illegal && err_count_reg != ERR_MAX) begin
            err_count_next = err_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_reg       <= '0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
            err_count_reg  <= '0;
        end else begin
            main_reg       <= main_next;
            main_valid_reg <= main_valid_next;
            skid_reg       <= skid_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= !skid_valid_next;
            err_count_reg  <= err_count_next;
        end
    end

    // Upper bits of the wide record are constant zero in narrow builds.
    logic unused_main;
    assign unused_main = ^main_reg;

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign imm_op    = main_reg.imm[XLEN-1:0];
    assign tag_out   = main_reg.tag[TAG_W-1:0];
    assign illegal   = main_reg.illegal;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: three configurations share one stimulus stream and are
// scored against a capacity-2 FIFO model with an arithmetic decode reference.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] e64;
        logic [31:0] e32;
        logic [31:0] tag;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  src;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, err_clr;
    logic [31:0] ins, tag_in;
    logic [2:0]  imm_src;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [31:0] a_imm, a_tag;
    logic [7:0]  a_err;
    logic        b_in_ready, b_out_valid, b_illegal;
    logic [63:0] b_imm;
    logic [31:0] b_tag;
    logic [7:0]  b_err;
    logic        c_in_ready, c_out_valid, c_illegal;
    logic [31:0] c_imm, c_tag;
    logic [1:0]  c_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   n_ret   = 0;
    int   cyc     = 0;
    int   cnt8    = 0;
    int   cnt2    = 0;
    exp_t q[$];
    exp_t pend;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ERR_CNT_W(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .ins(ins), .imm_src(imm_src), .tag_in(tag_in), .out_valid(a_out_valid),
        .out_ready(out_ready), .imm_op(a_imm), .tag_out(a_tag), .illegal(a_illegal),
        .err_clr(err_clr), .err_count(a_err)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ERR_CNT_W(8)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .ins(ins), .imm_src(imm_src), .tag_in(tag_in), .out_valid(b_out_valid),
        .out_ready(out_ready), .imm_op(b_imm), .tag_out(b_tag), .illegal(b_illegal),
        .err_clr(err_clr), .err_count(b_err)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ERR_CNT_W(2)) u_dutsat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .ins(ins), .imm_src(imm_src), .tag_in(tag_in), .out_valid(c_out_valid),
        .out_ready(out_ready), .imm_op(c_imm), .tag_out(c_tag), .illegal(c_illegal),
        .err_clr(err_clr), .err_count(c_err)
    );

    function automatic longint sx(input longint raw, input int bits);
        if (raw >= (longint'(1) <<< (bits - 1)))
            return raw - (longint'(1) <<< bits);
        return raw;
    endfunction

    // Reference decode: field value as a signed integer, then truncated per XLEN.
    function automatic exp_t ref_model(input logic [31:0] i, input logic [2:0] s,
                                       input logic [31:0] t);
        exp_t   e;
        longint v;
        e.tag = t;
        e.ill = 1'b0;
        v     = 0;
        case (s)
            3'd0: v = sx(longint'(i[31:20]), 12);
            3'd1: v = sx(longint'({i[31:25], i[11:7]}), 12);
            3'd2: v = sx(longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
            3'd3: v = sx(longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
            3'd4: v = sx(longint'(i[31:12]) * 4096, 32);
            3'd5: v = longint'(i[19:15]);
            default: begin v = 0; e.ill = (s == 3'd7); end
        endcase
        e.e64 = v;
        e.e32 = v[31:0];
        if (s == 3'd6) begin
            e.e32 = 32'(i[24:20]);
            e.e64 = 64'(i[25:20]);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s,
                         input logic [31:0] t);
        in_valid = v;
        ins      = i;
        imm_src  = s;
        tag_in   = t;
        pend     = ref_model(i, s, t);
    endtask

    task automatic check_outputs(input logic was_rst);
        logic exp_ready, exp_valid;
        exp_ready = (q.size() < 2);
        exp_valid = (q.size() > 0);
        chk("in_ready32", a_in_ready, exp_ready);
        chk("in_ready64", b_in_ready, exp_ready);
        chk("in_readysat", c_in_ready, exp_ready);
        chk("out_valid32", a_out_valid, exp_valid);
        chk("out_valid64", b_out_valid, exp_valid);
        chk("out_validsat", c_out_valid, exp_valid);
        chk("err32", a_err, cnt8);
        chk("err64", b_err, cnt8);
        chk("errsat", c_err, cnt2);
        if (exp_valid) begin
            chk("imm32", a_imm, q[0].e32);
            chk("imm64", b_imm, q[0].e64);
            chk("immsat", c_imm, q[0].e32);
            chk("tag32", a_tag, q[0].tag);
            chk("tag64", b_tag, q[0].tag);
            chk("ill32", a_illegal, q[0].ill);
            chk("ill64", b_illegal, q[0].ill);
        end
        if (was_rst) begin
            chk("rst_imm32", a_imm, 0);
            chk("rst_imm64", b_imm, 0);
            chk("rst_tag32", a_tag, 0);
            chk("rst_ill32", a_illegal, 0);
        end
    endtask

    task automatic cycle();
        logic acc, ret, was_rst;
        exp_t r;
        was_rst = rst;
        acc     = in_valid && (q.size() < 2);
        ret     = (q.size() > 0) && out_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) begin
            q.delete();
            cnt8 = 0;
            cnt2 = 0;
        end else begin
            if (ret) begin
                r = q.pop_front();
                n_ret++;
                $display("[TB] cyc=%0d retire tag=%08h imm32=%08h imm64=%016h ill=%0b",
                         cyc, r.tag, r.e32, r.e64, r.ill);
            end
            if (acc) begin
                q.push_back(pend);
                n_acc++;
            end
            if (err_clr) begin
                cnt8 = 0;
                cnt2 = 0;
            end else if (acc && imm_src == 3'd7) begin
                if (cnt8 < 255) cnt8++;
                if (cnt2 < 3)   cnt2++;
            end
        end
        check_outputs(was_rst);
    endtask

    vec_t vecs[11];
    int   base_acc, base_ret;

    initial begin
        vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[2]  = '{32'hFF9FF06F, 3'd3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
        vecs[3]  = '{32'h123450B7, 3'd4, 32'h12345000, 64'h0000000012345000, 1'b0};
        vecs[4]  = '{32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[5]  = '{32'h03F00013, 3'd6, 32'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[6]  = '{32'h000F8073, 3'd5, 32'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[7]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[8]  = '{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
        vecs[10] = '{32'h00000000, 3'd4, 32'h00000000, 64'h0000000000000000, 1'b0};

        rst = 1'b1; err_clr = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        repeat (3) cycle();
        rst = 1'b0;

        // Directed table streamed back-to-back with out_ready high.
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, vecs[k].ins, vecs[k].src, 32'h1000 + k * 4);
            pend.e32 = vecs[k].e32;
            pend.e64 = vecs[k].e64;
            pend.ill = vecs[k].ill;
            cycle();
        end
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        repeat (3) cycle();

        // Backpressure: three stalled cycles accept exactly two requests.
        base_acc = n_acc;
        base_ret = n_ret;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, $urandom, 3'($urandom_range(0, 6)), 32'hB000 + k);
            cycle();
        end
        chk("bp_accepts", n_acc - base_acc, 2);
        chk("bp_ready_low", a_in_ready, 1'b0);
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("bp_retired", n_ret - base_ret, 2);

        // Illegal-selector counter: count, clear-priority, saturation.
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, $urandom, 3'd7, 32'hE000 + k);
            cycle();
        end
        chk("err_three", a_err, 3);
        err_clr = 1'b1;
        drive(1'b1, $urandom, 3'd7, 32'hE003);
        cycle();
        err_clr = 1'b0;
        chk("err_clr_wins", a_err, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, $urandom, 3'd7, 32'hE010 + k);
            cycle();
        end
        chk("err_five", a_err, 5);
        chk("err_saturate", c_err, 3);
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        repeat (3) cycle();

        // Reset with both entries full, then a clean post-reset request.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, $urandom, 3'd7, 32'hD000 + k);
            cycle();
        end
        chk("full_ready_low", a_in_ready, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_ready", a_in_ready, 1'b1);
        chk("rst_valid", a_out_valid, 1'b0);
        chk("rst_err", a_err, 0);
        out_ready = 1'b1;
        drive(1'b1, 32'h123450B7, 3'd4, 32'hD100);
        cycle();
        chk("post_rst_imm", a_imm, 32'h12345000);
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        cycle();

        // Random valid/ready traffic against the reference model.
        base_ret = n_ret;
        for (int k = 0; k < 40000 && (n_ret - base_ret) < 10000; k++) begin
            drive(($urandom % 4) != 0, $urandom, 3'($urandom), $urandom);
            out_ready = ($urandom % 3) != 0;
            err_clr   = ($urandom % 64) == 0;
            cycle();
        end
        err_clr = 1'b0;
        chk("rand_completed", (n_ret - base_ret) >= 10000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. It accepts an instruction word, an immediate-type selector and a sideband tag over a valid/ready handshake. One cycle later it returns the XLEN-wide extended immediate, the tag and an illegal flag. It adds RV64 support, CSR-zimm and shift-amount modes, a registered skid buffer for full throughput under backpressure, and a saturating illegal-selector counter in place of a simulation-only error.

Parameters:
XLEN, 32, datapath width of imm_op; legal values 32 or 64; any other value is an elaboration error.
TAG_W, 32, width of the pass-through tag (typically PC).
ERR_CNT_W, 8, width of the saturating illegal-selector counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request; driven from a register.
ins  in  32  full instruction word.
imm_src  in  3  immediate type: 0 I, 1 S, 2 B, 3 J, 4 U, 5 Z (CSR zimm), 6 SHAMT, 7 reserved.
tag_in  in  TAG_W  sideband data, passed through unchanged.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
imm_op  out  XLEN  extended immediate.
tag_out  out  TAG_W  tag of the current result.
illegal  out  1  current result came from a reserved imm_src.
err_clr  in  1  synchronous clear of err_count.
err_count  out  ERR_CNT_W  saturating count of accepted illegal requests.

Behaviour:
- Reset:
  - in_ready=1, out_valid=0, imm_op=0, tag_out=0, illegal=0, err_count=0.
  - Both storage entries are invalidated.
  - Reset asserted in the middle of a transfer discards everything held; the next edge after rst deasserts may accept.
- Transfers:
  - Accept when in_valid && in_ready.
  - Retire when out_valid && out_ready.
- Decode modes (combinational, sign bit = ins[31]; each result is sign-extended to XLEN unless stated):
  - I: ins[31:20].
  - S: {ins[31:25], ins[11:7]}.
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
  - U: {ins[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - Z: ins[19:15], zero-extended.
  - SHAMT: ins[24:20] when XLEN=32, or ins[25:20] when XLEN=64, zero-extended.
  - 7: imm_op=0 and illegal=1. No $error is raised.
- Storage:
  - Output register (main) plus one skid entry.
  - Latency is 1 cycle: a request accepted at edge N appears on the outputs after edge N.
- Main register update at each edge:
  - Load the decode of the current input if an accept happens and (main is empty or retiring) and skid is empty.
  - Else, if skid is valid and main is retiring, load main from skid.
- Skid entry:
  - Captures the accepted request when main is full and not retiring.
  - in_ready(next) = !skid_valid(next).
  - Skid is never written while it is valid.
- Ordering: results are strictly FIFO in acceptance order; no drop and no duplication.
- Throughput: with out_ready held at 1, one result per cycle.
- Simultaneous accept, retire and skid-valid: main takes skid and skid takes the new request. This cannot occur in practice because in_ready=0 whenever skid is valid.
- err_count:
  - +1 on each accepted request with imm_src=7.
  - Saturates at 2^ERR_CNT_W-1.
  - err_clr has priority over an increment in the same cycle; the result is 0.
- Outputs hold stable while out_valid && !out_ready.

Decomposition:
- Shared package imm_pkg holds:
  - imm_src_e enum with IMM_I…IMM_SHAMT and IMM_RSVD=7.
  - XLEN legality check.
  - A result struct {imm, tag, illegal} used by both storage entries.
- Sub-module imm_decode: purely combinational ins/imm_src → {imm, illegal}, parametrised by XLEN.
- imm_gen_pipe contains only the handshake, storage and counter.

Test Plan:
1. XLEN=32, out_ready=1: stream I 0xFFF00093 → 0xFFFFFFFF; S 0xFE112E23 → 0xFFFFFFFC; J 0xFF9FF06F → 0xFFFFFFF8; U 0x123450B7 → 0x12345000. Each result arrives one cycle after accept, one per cycle, and tags match.
2. XLEN=64: U 0x800000B7 → 0xFFFFFFFF80000000; SHAMT with ins[25:20]=63 → 0x3F; Z with ins[19:15]=5'b11111 → 0x1F.
3. Backpressure: out_ready=0 for 3 cycles while in_valid=1 → exactly 2 accepted, in_ready falls after the 2nd. Release → results in order, with no loss or duplicates.
4. imm_src=7 accepted 3 times → imm_op=0, illegal=1, err_count=3. Then err_clr together with a 4th illegal accept → err_count=0. With ERR_CNT_W=2, 5 illegal accepts → err_count saturates at 3.
5. rst asserted while main and skid are both full → next cycle out_valid=0, in_ready=1, err_count=0; the first post-reset request returns correctly.
6. Random valid/ready (≥10k transfers) against a reference decode model → every result bit-exact and in order; outputs stable while stalled.
